// File: rtl/tb_multi_pass_monitor.sv
// Simulation completion monitor: classifies per-channel tohost writes and drives a global verdict.
// All outputs are registered (1-cycle latency); the monitor only observes, so it applies no backpressure.
module tb_multi_pass_monitor #(
    parameter int                 NCH      = 2,
    parameter int                 XLEN     = 64,
    parameter int                 CNT_W    = 32,
    parameter logic [XLEN-1:0]    PASS_VAL = {{(XLEN-1){1'b0}}, 1'b1},
    parameter int unsigned        TIMEOUT  = 1000000
) (
    input  logic                                     tb_clk,
    input  logic                                     tb_rst_n,
    input  logic [NCH-1:0]                           cmt_valid,
    input  logic [NCH-1:0]                           tohost_wr,
    input  logic [NCH*XLEN-1:0]                      tohost_data,
    input  logic [NCH-1:0]                           ifu_fire,
    output logic [CNT_W-1:0]                         cycle_count,
    output logic [1:0]                               state,
    output logic                                     done,
    output logic [NCH-1:0]                           ch_done,
    output logic [NCH*CNT_W-1:0]                     ch_end_cycle,
    output logic [NCH*CNT_W-1:0]                     ch_inst_cnt,
    output logic [CNT_W-1:0]                         tohost_cnt,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] fail_ch,
    output logic [XLEN-1:0]                          fail_code
);

    localparam int FCW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW  = CNT_W + 4;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    state_e            state_q;
    logic              done_q;
    logic [FCW-1:0]    fail_ch_q;
    logic [XLEN-1:0]   fail_code_q;
    logic [CNT_W-1:0]  cyc_q;
    logic [CNT_W-1:0]  tohost_cnt_q;
    logic [NCH-1:0]    ch_done_q;
    logic [CNT_W-1:0]  end_q  [NCH];
    logic [CNT_W-1:0]  inst_q [NCH];

    logic [XLEN-1:0]   dat [NCH];
    logic [NCH-1:0]    ev;
    logic [NCH-1:0]    exit_ev;
    logic [NCH-1:0]    live_fail;
    logic              all_done_d;
    logic [FCW-1:0]    fsel_d;
    logic [XLEN-1:0]   fcode_d;
    logic [SW-1:0]     th_sum_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign dat[g] = tohost_data[g*XLEN +: XLEN];
        assign ch_end_cycle[g*CNT_W +: CNT_W] = end_q[g];
        assign ch_inst_cnt[g*CNT_W +: CNT_W]  = inst_q[g];
    end

    // Odd data other than PASS_VAL is a failure exit; even data is just a console/scratch write.
    always_comb begin
        ev        = '0;
        exit_ev   = '0;
        live_fail = '0;
        for (int i = 0; i < NCH; i++) begin
            ev[i]        = cmt_valid[i] & tohost_wr[i];
            exit_ev[i]   = ev[i] & ((dat[i] == PASS_VAL) | dat[i][0]);
            live_fail[i] = ev[i] & (dat[i] != PASS_VAL) & dat[i][0] & ~ch_done_q[i];
        end
        all_done_d = &(ch_done_q | exit_ev);
    end

    // Descending scan leaves the lowest-index failing channel selected.
    always_comb begin
        fsel_d  = '0;
        fcode_d = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (live_fail[i]) begin
                fsel_d  = FCW'(i);
                fcode_d = dat[i] >> 1;
            end
        end
    end

    always_comb begin
        th_sum_d = {4'b0, tohost_cnt_q};
        for (int i = 0; i < NCH; i++) begin
            if (ev[i]) begin
                th_sum_d = th_sum_d + SW'(1);
            end
        end
    end

    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            cyc_q        <= '0;
            tohost_cnt_q <= '0;
        end else begin
            if (cyc_q != '1) begin
                cyc_q <= cyc_q + CNT_W'(1);
            end
            tohost_cnt_q <= (|th_sum_d[SW-1:CNT_W]) ? '1 : th_sum_d[CNT_W-1:0];
        end
    end

    // Channel captures keep running after a terminal verdict.
    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            ch_done_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                end_q[i]  <= '0;
                inst_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!ch_done_q[i]) begin
                    if (ifu_fire[i] && (inst_q[i] != '1)) begin
                        inst_q[i] <= inst_q[i] + CNT_W'(1);
                    end
                    if (exit_ev[i]) begin
                        ch_done_q[i] <= 1'b1;
                        end_q[i]     <= cyc_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge tb_clk or negedge tb_rst_n) begin
        if (!tb_rst_n) begin
            state_q     <= ST_RUN;
            done_q      <= 1'b0;
            fail_ch_q   <= '0;
            fail_code_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (|live_fail) begin
                        state_q     <= ST_FAIL;
                        done_q      <= 1'b1;
                        fail_ch_q   <= fsel_d;
                        fail_code_q <= fcode_d;
                    end else if (all_done_d) begin
                        state_q <= ST_PASS;
                        done_q  <= 1'b1;
                    end else if ((TIMEOUT != 0) && (cyc_q == TO_LAST)) begin
                        state_q <= ST_TIMEOUT;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= state_q;
            endcase
        end
    end

    assign cycle_count = cyc_q;
    assign state       = state_q;
    assign done        = done_q;
    assign ch_done     = ch_done_q;
    assign tohost_cnt  = tohost_cnt_q;
    assign fail_ch     = fail_ch_q;
    assign fail_code   = fail_code_q;

endmodule
